// File: rtl/sim_cmd_decoder.sv
// Byte-stream command decoder that stands in for the simulation harness stdin loop.
// Drives a DUT's packed inputs, reset and step-enable; streams output snapshots back as bytes.
module sim_cmd_decoder #(
   parameter int INPUT_SIZE  = 16,
   parameter int OUTPUT_SIZE = 32,
   parameter int STEP_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             cmd_data,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   output logic [7:0]             resp_data,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [INPUT_SIZE-1:0]  dut_data_in,
   input  logic [OUTPUT_SIZE-1:0] dut_data_out,
   output logic                   dut_rst,
   output logic                   dut_step,
   output logic                   halted,
   output logic                   error,
   output logic [2:0]             state_dbg
);

   localparam int INPUT_BYTES  = (INPUT_SIZE + 7) / 8;
   localparam int STAGE_W      = INPUT_BYTES * 8;
   localparam int OUTPUT_WORDS = (OUTPUT_SIZE + 31) / 32;
   localparam int SNAP_W       = OUTPUT_WORDS * 32;
   localparam int SEND_BYTES   = OUTPUT_WORDS * 4;
   localparam int SEND_CNT_W   = $clog2(SEND_BYTES);
   localparam int LOAD_CNT_W   = $clog2(INPUT_BYTES + 1);
   localparam int STEP_CNT_W   = $clog2(STEP_CYCLES + 1);

   localparam logic [SEND_CNT_W-1:0] LAST_SEND = SEND_CNT_W'(SEND_BYTES - 1);
   localparam logic [LOAD_CNT_W-1:0] LAST_LOAD = LOAD_CNT_W'(INPUT_BYTES - 1);
   localparam logic [STEP_CNT_W-1:0] STEP_LOAD = STEP_CNT_W'(STEP_CYCLES);
   localparam logic [STEP_CNT_W-1:0] STEP_LAST = STEP_CNT_W'(1);

   localparam logic [7:0] CMD_READ    = 8'h68;
   localparam logic [7:0] CMD_HALT    = 8'h69;
   localparam logic [7:0] CMD_RST_ON  = 8'h6A;
   localparam logic [7:0] CMD_RST_OFF = 8'h6B;
   localparam logic [7:0] CMD_STEP    = 8'h6C;
   localparam logic [7:0] CMD_LOAD    = 8'h6D;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_STEP = 3'd2,
      S_SEND = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t                  state, state_next;
   logic                    cmd_ready_raw, resp_valid_raw, dut_step_raw;
   logic                    cmd_accept, resp_accept;
   logic                    error_q;
   logic [STAGE_W-1:0]      staging, staging_shift;
   logic [LOAD_CNT_W-1:0]   load_cnt;
   logic [STEP_CNT_W-1:0]   step_cnt;
   logic [SNAP_W-1:0]       snapshot;
   logic [SEND_CNT_W-1:0]   send_cnt;

   // Handshakes: a byte moves on a rising edge only when valid && ready are both high;
   // the producer holds data stable until then, and ready never depends on valid.
   assign cmd_accept  = cmd_valid && cmd_ready;
   assign resp_accept = resp_valid && resp_ready;

   // Payload arrives least-significant byte first, so new bytes enter at the top.
   assign staging_shift = (staging >> 8) | (STAGE_W'(cmd_data) << (STAGE_W - 8));

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next     = state;
      cmd_ready_raw  = 1'b0;
      resp_valid_raw = 1'b0;
      dut_step_raw   = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready_raw = 1'b1;
            if (cmd_valid) begin
               case (cmd_data)
                  CMD_READ:    state_next = S_SEND;
                  CMD_HALT:    state_next = S_HALT;
                  CMD_RST_ON:  state_next = S_IDLE;
                  CMD_RST_OFF: state_next = S_IDLE;
                  CMD_STEP:    state_next = S_STEP;
                  CMD_LOAD:    state_next = S_LOAD;
                  default:     state_next = S_HALT;
               endcase
            end
         end
         S_LOAD: begin
            cmd_ready_raw = 1'b1;
            if (cmd_valid && load_cnt == LAST_LOAD) state_next = S_IDLE;
         end
         S_STEP: begin
            dut_step_raw = 1'b1;
            if (step_cnt == STEP_LAST) state_next = S_IDLE;
         end
         S_SEND: begin
            resp_valid_raw = 1'b1;
            if (resp_ready && send_cnt == LAST_SEND) state_next = S_IDLE;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   // Status outputs are forced inactive for the whole time reset is held.
   assign cmd_ready  = rst && cmd_ready_raw;
   assign resp_valid = rst && resp_valid_raw;
   assign dut_step   = rst && dut_step_raw;
   assign halted     = rst && (state == S_HALT);
   assign error      = rst && error_q;
   assign resp_data  = resp_valid ? snapshot[7:0] : 8'h00;
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         dut_rst     <= 1'b1;
         dut_data_in <= '0;
         staging     <= '0;
         load_cnt    <= '0;
         step_cnt    <= '0;
         snapshot    <= '0;
         send_cnt    <= '0;
         error_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_accept) begin
                  case (cmd_data)
                     CMD_READ: begin
                        snapshot <= SNAP_W'(dut_data_out);
                        send_cnt <= '0;
                     end
                     CMD_HALT:    ;
                     CMD_RST_ON:  dut_rst  <= 1'b1;
                     CMD_RST_OFF: dut_rst  <= 1'b0;
                     CMD_STEP:    step_cnt <= STEP_LOAD;
                     CMD_LOAD:    load_cnt <= '0;
                     default:     error_q  <= 1'b1;
                  endcase
               end
            end
            S_LOAD: begin
               if (cmd_accept) begin
                  staging  <= staging_shift;
                  load_cnt <= load_cnt + 1'b1;
                  if (load_cnt == LAST_LOAD) dut_data_in <= staging_shift[INPUT_SIZE-1:0];
               end
            end
            S_STEP: step_cnt <= step_cnt - 1'b1;
            S_SEND: begin
               if (resp_accept) begin
                  snapshot <= snapshot >> 8;
                  send_cnt <= send_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sim_cmd_decoder.sv
// Directed-plus-random bench for sim_cmd_decoder against a byte-level protocol model.
// A second instance with a 3-cycle step shares all stimulus to cover wider step pulses.
module tb_sim_cmd_decoder;

   localparam int IN_W   = 16;
   localparam int OUT_W  = 40;
   localparam int NBYTES = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        cmd_data;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        resp_data;
   logic              resp_valid;
   logic              resp_ready;
   logic [IN_W-1:0]   dut_data_in;
   logic [OUT_W-1:0]  dut_data_out;
   logic              dut_rst, dut_step, halted, error;
   logic [2:0]        state_dbg;

   logic              cmd_ready3, resp_valid3, dut_rst3, dut_step3, halted3, error3;
   logic [7:0]        resp_data3;
   logic [IN_W-1:0]   dut_data_in3;
   logic [2:0]        state_dbg3;

   int                vectors = 0;
   int                miscompares = 0;
   int                last_wait;
   logic [7:0]        exp_q[$];
   logic [IN_W-1:0]   model_din;
   logic              model_rst;

   always #5 clk = ~clk;

   sim_cmd_decoder #(.INPUT_SIZE(IN_W), .OUTPUT_SIZE(OUT_W), .STEP_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .dut_data_in(dut_data_in), .dut_data_out(dut_data_out), .dut_rst(dut_rst),
      .dut_step(dut_step), .halted(halted), .error(error), .state_dbg(state_dbg)
   );

   sim_cmd_decoder #(.INPUT_SIZE(IN_W), .OUTPUT_SIZE(OUT_W), .STEP_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
      .resp_data(resp_data3), .resp_valid(resp_valid3), .resp_ready(resp_ready),
      .dut_data_in(dut_data_in3), .dut_data_out(dut_data_out), .dut_rst(dut_rst3),
      .dut_step(dut_step3), .halted(halted3), .error(error3), .state_dbg(state_dbg3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one byte and hold it until accepted; returns just after the accept edge.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited    = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
      last_wait = waited;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      cmd_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("rst_cmd_ready", cmd_ready, 0);
         check("rst_resp_valid", resp_valid, 0);
         check("rst_resp_data", resp_data, 0);
         check("rst_halted", halted, 0);
         check("rst_error", error, 0);
         check("rst_dut_step", dut_step, 0);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      model_din = '0;
      model_rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_resp_valid", resp_valid, 0);
      check("post_rst_dut_data_in", dut_data_in, model_din);
      check("post_rst_dut_rst", dut_rst, model_rst);
      check("post_rst_halted", halted, 0);
      check("post_rst_error", error, 0);
      @(posedge clk); #1;
   endtask

   task automatic set_rst_cmd(input logic v);
      send_byte(v ? 8'h6A : 8'h6B);
      model_rst = v;
      check(v ? "dut_rst_after_j" : "dut_rst_after_k", dut_rst, model_rst);
      check("din_stable_rstcmd", dut_data_in, model_din);
   endtask

   task automatic load_word(input logic [IN_W-1:0] v);
      send_byte(8'h6D);
      send_byte(v[7:0]);
      check("load_no_bubble", last_wait, 0);
      check("din_held_mid_load", dut_data_in, model_din);
      send_byte(v[15:8]);
      check("load_no_bubble", last_wait, 0);
      model_din = v;
      check("din_after_load", dut_data_in, model_din);
   endtask

   // mode 0: resp_ready toggles 0/1, mode 1: held high, mode 2: random
   task automatic read_snapshot(input logic [OUT_W-1:0] val, input int mode);
      logic [63:0] ext;
      int cycles;
      ext = 64'(val);
      dut_data_out = val;
      send_byte(8'h68);
      for (int i = 0; i < NBYTES; i++) exp_q.push_back(8'((ext >> (8 * i)) & 64'hFF));
      dut_data_out = {8'($urandom_range(0, 255)), 32'($urandom)};
      cycles = 0;
      while (exp_q.size() > 0 && cycles < 100) begin
         case (mode)
            0:       resp_ready = ((cycles % 2) == 1);
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         check("send_resp_valid", resp_valid, 1);
         check("send_resp_data", resp_data, exp_q[0]);
         check("send_cmd_ready", cmd_ready, 0);
         if (resp_ready) void'(exp_q.pop_front());
         @(posedge clk); #1;
         cycles++;
      end
      if (exp_q.size() > 0) check("send_timeout", exp_q.size(), 0);
      resp_ready = 1'b0;
      if (mode == 1) check("send_one_per_cycle", cycles, NBYTES);
      @(negedge clk);
      check("send_done_resp_valid", resp_valid, 0);
      check("send_done_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [5:0]  step_pat, ready_pat, step3_pat, ready3_pat;
      logic [7:0]  b;
      logic [OUT_W-1:0] v;
      rst = 1'b0;
      cmd_valid = 1'b0;
      cmd_data = 8'h00;
      resp_ready = 1'b0;
      dut_data_out = '0;
      model_din = '0;
      model_rst = 1'b1;
      @(posedge clk); #1;
      do_reset(2);

      set_rst_cmd(1'b0);
      set_rst_cmd(1'b1);

      load_word(16'h1234);
      load_word(16'hABCD);

      read_snapshot(40'hAB_DEAD_BEEF, 0);
      read_snapshot({8'($urandom_range(0, 255)), 32'($urandom)}, 1);

      send_byte(8'h6C);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         step_pat[i]   = dut_step;
         ready_pat[i]  = cmd_ready;
         step3_pat[i]  = dut_step3;
         ready3_pat[i] = cmd_ready3;
         @(posedge clk); #1;
      end
      check("step1_pulse", step_pat, 6'b000001);
      check("step1_cmd_ready", ready_pat, 6'b111110);
      check("step3_pulse", step3_pat, 6'b000111);
      check("step3_cmd_ready", ready3_pat, 6'b111000);
      check("step_din_stable", dut_data_in, model_din);

      for (int it = 0; it < 10; it++) begin
         case ($urandom_range(0, 3))
            0:       load_word(16'($urandom));
            1:       set_rst_cmd(1'b1);
            2:       set_rst_cmd(1'b0);
            default: read_snapshot({8'($urandom_range(0, 255)), 32'($urandom)}, 2);
         endcase
      end

      send_byte(8'h6D);
      send_byte(8'h55);
      do_reset(1);
      set_rst_cmd(1'b0);
      load_word(16'($urandom));

      v = {8'($urandom_range(0, 255)), 32'($urandom)};
      dut_data_out = v;
      send_byte(8'h68);
      for (int i = 0; i < NBYTES; i++) exp_q.push_back(8'((64'(v) >> (8 * i)) & 64'hFF));
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midsend_resp_valid", resp_valid, 1);
         check("midsend_resp_data", resp_data, exp_q.pop_front());
         @(posedge clk); #1;
      end
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midsend_no_more_bytes", resp_valid, 0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b0;

      load_word(16'hC3A5);
      send_byte(8'h41);
      check("unk_halted", halted, 1);
      check("unk_error", error, 1);
      check("unk_cmd_ready", cmd_ready, 0);
      cmd_data = 8'h6B;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("halt_cmd_ready", cmd_ready, 0);
         check("halt_halted", halted, 1);
         check("halt_resp_valid", resp_valid, 0);
         check("halt_dut_rst", dut_rst, model_rst);
         check("halt_din", dut_data_in, model_din);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      do_reset(1);

      send_byte(8'h69);
      check("i_halted", halted, 1);
      check("i_error", error, 0);
      check("i_cmd_ready", cmd_ready, 0);
      do_reset(1);

      for (int it = 0; it < 3; it++) begin
         do b = 8'($urandom_range(0, 255)); while (b >= 8'h68 && b <= 8'h6D);
         send_byte(b);
         check("rand_unk_halted", halted, 1);
         check("rand_unk_error", error, 1);
         do_reset(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sim_cmd_decoder.md
# sim_cmd_decoder

Synthesizable byte-stream command decoder that sits directly upstream of a DUT in place of the simulation harness's stdin loop. It consumes the same command byte protocol ('h' read outputs, 'i' halt, 'j'/'k' assert/release DUT reset, 'l' step, 'm' load inputs) over a valid/ready byte stream, typically from a UART or host FIFO. It drives the DUT's packed input vector, reset and step-enable, and streams snapshots of the DUT's packed output vector back as little-endian 32-bit words.

## Interface
- INPUT_SIZE, 16: width of packed DUT input vector; must be ≥ 8.
- OUTPUT_SIZE, 32: width of packed DUT output vector.
- STEP_CYCLES, 1: cycles `dut_step` stays high per 'l' command; must be ≥ 1.
- Derived values:
  - INPUT_BYTES = ceil(INPUT_SIZE/8).
  - OUTPUT_WORDS = ceil(OUTPUT_SIZE/32).

- clk  in  1  single clock.
- rst  in  1  reset is synchronous and active-low (asserted when 0).
- cmd_data  in  8  command/payload byte.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  byte accepted on clk edge when cmd_valid && cmd_ready.
- resp_data  out  8  response byte.
- resp_valid  out  1  resp_data valid.
- resp_ready  in  1  response byte consumed on edge when resp_valid && resp_ready.
- dut_data_in  out  INPUT_SIZE  packed DUT inputs.
- dut_data_out  in  OUTPUT_SIZE  packed DUT outputs.
- dut_rst  out  1  DUT reset, active-high.
- dut_step  out  1  DUT clock enable.
- halted  out  1  decoder stopped; only rst clears.
- error  out  1  unknown command received.

## Operation
- FSM states:
  - IDLE: cmd_ready=1; decodes the accepted byte.
    - 104 'h': capture dut_data_out into snapshot register, zero-extended to OUTPUT_WORDS*32 bits; go to SEND.
    - 105 'i': go to HALT with error=0.
    - 106 'j': dut_rst←1; stay in IDLE.
    - 107 'k': dut_rst←0; stay in IDLE.
    - 108 'l': load step counter with STEP_CYCLES; go to STEP.
    - 109 'm': clear byte counter; go to LOAD.
    - any other value: go to HALT with error←1.
  - LOAD: cmd_ready=1.
    - Each accepted byte shifts into a staging register: staging←{byte, staging[INPUT_SIZE-1:8]}, keeping the low INPUT_SIZE bits.
    - After INPUT_BYTES bytes, staging is copied to dut_data_in; go to IDLE.
    - Payload bytes are never decoded as commands.
  - STEP: cmd_ready=0, dut_step=1; counter decrements; after STEP_CYCLES cycles, go to IDLE.
  - SEND: cmd_ready=0.
    - Emits OUTPUT_WORDS*4 bytes: word 0 first; within each word bits [7:0] first, then [15:8], [23:16], [31:24].
    - After the last byte handshake, go to IDLE.
  - HALT: cmd_ready=0, resp_valid=0, halted=1. Exit only via rst.
- dut_data_in changes only on completion of an 'm' sequence.
- dut_step is 1 only in STEP.

## Timing
- Reset values while rst=0 and on the first cycle after release:
  - state=IDLE
  - cmd_ready=0 during reset, 1 the first cycle after release
  - resp_valid=0, resp_data=0
  - dut_data_in=0
  - dut_rst=1, dut_step=0
  - halted=0, error=0
- 'j'/'k': dut_rst changes on the edge that accepts the byte, visible the next cycle.
- 'm': dut_data_in updates on the edge that accepts the final payload byte. Back-to-back commands are accepted with no bubble.
- 'l': dut_step is high for exactly cycles N+1 .. N+STEP_CYCLES, where N is the accept edge. cmd_ready is 1 again at cycle N+STEP_CYCLES+1.
- 'h': snapshot is sampled at the accept edge N; resp_valid=1 from cycle N+1.
  - resp_data/resp_valid hold stable while resp_ready=0.
  - One byte per cycle when resp_ready is held 1.
  - cmd_ready returns to 1 the cycle after the last byte handshake.
- Changes to dut_data_out during SEND do not affect the emitted bytes.
- Reset mid-LOAD discards the partial staging data. Reset mid-SEND drops the remaining bytes; resp_valid=0 the next cycle.
- cmd_valid while cmd_ready=0 is ignored. The source holds the byte until it is accepted.

## Test plan
- Parameters for all scenarios: INPUT_SIZE=16, OUTPUT_SIZE=40, STEP_CYCLES=1.
- Reset, then send 0x6B then 0x6A: dut_rst=1 after reset, 0 the cycle after 0x6B is accepted, 1 the cycle after 0x6A is accepted.
- Send 0x6D,0x34,0x12: dut_data_in stays 0 until the 0x12 accept edge, then becomes 0x1234. A following 0x6D,0xCD,0xAB yields 0xABCD.
- dut_data_out=0xAB_DEADBEEF, send 0x68, with resp_ready toggling 1/0: byte sequence EF,BE,AD,DE,AB,00,00,00; each byte is held while stalled. dut_data_out changes after the accept have no effect.
- Send 0x6C: dut_step is high for exactly one cycle, with cmd_ready=0 in that cycle. With STEP_CYCLES=3, the pulse is 3 cycles wide.
- Send 0x41: halted=1, error=1, cmd_ready=0 permanently. rst=0 for one cycle clears all three. Separately, 0x69 gives halted=1 with error=0.
- Send 0x68, consume 3 bytes, then pulse rst: resp_valid=0 after reset and no further bytes are emitted. dut_data_in=0, dut_rst=1.
